// File: rtl/vec_pkg.sv
// Shared vector-ALU definitions: geometry constants, beat/vector types,
// and the gather state encoding used by the fork/join sequencing.
package vec_pkg;

  localparam int N      = 32;
  localparam int V      = 20;
  localparam int LANES  = 4;
  localparam int SLICES = V / LANES;
  localparam int SW     = $clog2(SLICES);

  typedef logic [LANES-1:0][N-1:0] lane_beat_t;
  typedef logic [V-1:0][N-1:0]     vector_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } join_state_t;

  // Lane k of slice s lands in element k*SLICES+s (inverse of the fork stage)
  function automatic int elem_index(input int lane, input int slice);
    return lane * SLICES + slice;
  endfunction

endpackage

// File: rtl/join_slice_writer.sv
// Scatter network for the join stage: routes each lane of the current beat
// to its element position and raises the write enables of the elements
// owned by the active slice.
module join_slice_writer
  import vec_pkg::*;
(
  input  logic               accept,
  input  logic [SW-1:0]      slice_cnt,
  input  lane_beat_t         lane_res,
  output logic [V-1:0]       elem_we,
  output vector_t            elem_data
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar s = 0; s < SLICES; s++) begin : g_slice
      localparam int E = elem_index(k, s);
      assign elem_we[E]   = accept && (slice_cnt == SW'(s));
      assign elem_data[E] = lane_res[k];
    end
  end

endmodule

// File: rtl/join_vector.sv
// Gather/reassembly stage after the 4-lane vector ALU. Collects SLICES
// lane beats into one V-element vector and holds it for writeback until
// acknowledged. Optional running element sum enabled by JOIN_VECTOR_REDUCE_EN.
module join_vector
  import vec_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SW-1:0]      slice_idx_i,
  input  lane_beat_t         lane_res_i,
  output vector_t            result_o,
  output logic               result_valid_o,
  input  logic               result_ack_i,
  output logic               busy_o,
  output logic               err_o
`ifdef JOIN_VECTOR_REDUCE_EN
  ,
  output logic [N-1:0]       reduce_o
`endif
);

  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);

  join_state_t    state;
  logic [SW-1:0]  slice_cnt;
  logic           beat_accept;
  logic [V-1:0]   elem_we;
  vector_t        elem_data;

  // A restart in the same cycle wins over the beat, so the beat is not taken
  assign beat_accept = in_valid_i && in_ready_o && !start_i;

  join_slice_writer u_writer (
    .accept    (beat_accept),
    .slice_cnt (slice_cnt),
    .lane_res  (lane_res_i),
    .elem_we   (elem_we),
    .elem_data (elem_data)
  );

  // Control FSM with registered handshake/status outputs and the result store
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= IDLE;
      slice_cnt      <= '0;
      result_o       <= '0;
      in_ready_o     <= 1'b0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= COLLECT;
            slice_cnt  <= '0;
            result_o   <= '0;
            err_o      <= 1'b0;
            in_ready_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        COLLECT: begin
          if (start_i) begin
            slice_cnt <= '0;
            result_o  <= '0;
            err_o     <= 1'b0;
          end else if (beat_accept) begin
            for (int e = 0; e < V; e++) begin
              if (elem_we[e]) begin
                result_o[e] <= elem_data[e];
              end
            end
            if (slice_idx_i != slice_cnt) begin
              err_o <= 1'b1;
            end
            if (slice_cnt == LAST_SLICE) begin
              state          <= DONE;
              slice_cnt      <= '0;
              in_ready_o     <= 1'b0;
              busy_o         <= 1'b0;
              result_valid_o <= 1'b1;
            end else begin
              slice_cnt <= slice_cnt + SW'(1);
            end
          end
        end
        DONE: begin
          if (result_ack_i) begin
            result_valid_o <= 1'b0;
            if (start_i) begin
              state      <= COLLECT;
              slice_cnt  <= '0;
              result_o   <= '0;
              err_o      <= 1'b0;
              in_ready_o <= 1'b1;
              busy_o     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state          <= IDLE;
          slice_cnt      <= '0;
          in_ready_o     <= 1'b0;
          result_valid_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

`ifdef JOIN_VECTOR_REDUCE_EN
  logic [N-1:0] beat_sum;
  logic [N-1:0] acc;
  logic         start_take;

  // Start is honoured everywhere except DONE without an acknowledge
  assign start_take = start_i && ((state != DONE) || result_ack_i);

  // Sum of the lanes of the current beat, wrapping at N bits
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_sum = beat_sum + lane_res_i[k];
    end
  end

  // Running sum of all accepted beats, discarded on every new vector
  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc <= '0;
    end else if (start_take) begin
      acc <= '0;
    end else if (beat_accept) begin
      acc <= acc + beat_sum;
    end
  end

  assign reduce_o = acc;
`endif

endmodule
